// File: rtl/alu_cmd_sequencer.sv
// Initiator for a combinational 32-bit ALU. Accepts one command at a time on a
// valid/ready channel, drives and holds the ALU inputs for SETTLE cycles,
// captures y/zero and returns a tagged response on a second valid/ready channel.
module alu_cmd_sequencer #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,

    // command channel
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,

    // ALU interface
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_f,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_zero,

    // response channel
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_y,
    output logic             rsp_zero,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_illegal,
    output logic [15:0]      op_count
);

    localparam int unsigned CntW = 4;

    // Settle counter is 4 bits wide, so only 1..15 can be represented.
    if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
        $error("alu_cmd_sequencer: SETTLE must be in 1..15");
    end

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDrive = 2'd1,
        StResp  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [WIDTH-1:0]  alu_a_q, alu_a_d;
    logic [WIDTH-1:0]  alu_b_q, alu_b_d;
    logic [2:0]        alu_f_q, alu_f_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]  rsp_y_q, rsp_y_d;
    logic              rsp_zero_q, rsp_zero_d;
    logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
    logic              rsp_illegal_q, rsp_illegal_d;
    logic [15:0]       op_count_q, op_count_d;
    logic              op_is_illegal;

    // Opcodes 3..5 have no ALU function; they are sequenced but their result is masked.
    assign op_is_illegal = (alu_f_q == 3'd3) || (alu_f_q == 3'd4) || (alu_f_q == 3'd5);

    // Next-state and datapath updates for the IDLE -> DRIVE -> RESP cycle.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        tag_d         = tag_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_f_d       = alu_f_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_y_d       = rsp_y_q;
        rsp_zero_d    = rsp_zero_q;
        rsp_tag_d     = rsp_tag_q;
        rsp_illegal_d = rsp_illegal_q;
        op_count_d    = op_count_q;

        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    alu_a_d = cmd_a;
                    alu_b_d = cmd_b;
                    alu_f_d = cmd_op;
                    tag_d   = cmd_tag;
                    cnt_d   = CntW'(SETTLE);
                    state_d = StDrive;
                end
            end
            StDrive: begin
                cnt_d = cnt_q - 1'b1;
                // Last settle cycle: ALU inputs have been stable long enough.
                if (cnt_q == CntW'(1)) begin
                    rsp_y_d       = op_is_illegal ? '0 : alu_y;
                    rsp_zero_d    = op_is_illegal ? 1'b1 : alu_zero;
                    rsp_illegal_d = op_is_illegal;
                    rsp_tag_d     = tag_q;
                    rsp_valid_d   = 1'b1;
                    state_d       = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + 16'd1;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d     = StIdle;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            tag_q         <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_f_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_y_q       <= '0;
            rsp_zero_q    <= 1'b0;
            rsp_tag_q     <= '0;
            rsp_illegal_q <= 1'b0;
            op_count_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tag_q         <= tag_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_f_q       <= alu_f_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_y_q       <= rsp_y_d;
            rsp_zero_q    <= rsp_zero_d;
            rsp_tag_q     <= rsp_tag_d;
            rsp_illegal_q <= rsp_illegal_d;
            op_count_q    <= op_count_d;
        end
    end

    assign cmd_ready   = (state_q == StIdle);
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_f       = alu_f_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_y       = rsp_y_q;
    assign rsp_zero    = rsp_zero_q;
    assign rsp_tag     = rsp_tag_q;
    assign rsp_illegal = rsp_illegal_q;
    assign op_count    = op_count_q;

endmodule
